// File: rtl/dsd_lab5_if.sv
// ============================================================================
//  Module      : dsd_lab5_if
//  Description : Display-driver bus. Carries the hex value and digit select
//                in, and the active-low segment and anode drives out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dsd_lab5_if;
  logic [3:0] a;
  logic [2:0] b;
  logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic       an_0, an_1, an_2, an_3, an_4, an_5, an_6, an_7;

  // Source of the digit/select, sink of the display drives
  modport master (
    output a, b,
    input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g,
    input  an_0, an_1, an_2, an_3, an_4, an_5, an_6, an_7
  );

  // The display driver itself
  modport slave (
    input  a, b,
    output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g,
    output an_0, an_1, an_2, an_3, an_4, an_5, an_6, an_7
  );
endinterface

`default_nettype wire

// File: rtl/dsd_lab5.sv
// ============================================================================
//  Module      : dsd_lab5
//  Description : Registered single-digit hex seven-segment driver for an
//                8-digit common-anode board. Segments and anodes are
//                active-low and come straight from flops (1-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsd_lab5 (
  input  logic         clk,
  input  logic         rst_n,
  dsd_lab5_if.slave    bus
);

  // Segment vectors are packed {g,f,e,d,c,b,a}; a 0 bit lights the segment.
  localparam logic [6:0] C_SEG_DARK = 7'b111_1111;
  localparam logic [7:0] C_AN_DARK  = 8'hFF;

  logic [6:0] w_seg;
  logic [7:0] w_an;
  logic [6:0] r_seg;
  logic [7:0] r_an;

  // Hex glyph decode; every 4-bit code maps to a defined pattern
  always_comb begin
    w_seg = C_SEG_DARK;
    case (bus.a)
      4'h0: w_seg = 7'b100_0000;
      4'h1: w_seg = 7'b111_1001;
      4'h2: w_seg = 7'b010_0100;
      4'h3: w_seg = 7'b011_0000;
      4'h4: w_seg = 7'b001_1001;
      4'h5: w_seg = 7'b001_0010;
      4'h6: w_seg = 7'b000_0010;
      4'h7: w_seg = 7'b111_1000;
      4'h8: w_seg = 7'b000_0000;
      4'h9: w_seg = 7'b001_0000;
      4'hA: w_seg = 7'b000_1000;
      4'hB: w_seg = 7'b000_0011;
      4'hC: w_seg = 7'b100_0110;
      4'hD: w_seg = 7'b010_0001;
      4'hE: w_seg = 7'b000_0110;
      4'hF: w_seg = 7'b000_1110;
      default: w_seg = C_SEG_DARK;
    endcase
  end

  // One-cold anode select: only the addressed digit is pulled low
  for (genvar k = 0; k < 8; k++) begin : g_an_decode
    assign w_an[k] = (bus.b != 3'(k));
  end

  // Output flops; reset blanks the whole display and wins over new inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg <= C_SEG_DARK;
      r_an  <= C_AN_DARK;
    end else begin
      r_seg <= w_seg;
      r_an  <= w_an;
    end
  end

  assign bus.seg_a = r_seg[0];
  assign bus.seg_b = r_seg[1];
  assign bus.seg_c = r_seg[2];
  assign bus.seg_d = r_seg[3];
  assign bus.seg_e = r_seg[4];
  assign bus.seg_f = r_seg[5];
  assign bus.seg_g = r_seg[6];

  assign bus.an_0 = r_an[0];
  assign bus.an_1 = r_an[1];
  assign bus.an_2 = r_an[2];
  assign bus.an_3 = r_an[3];
  assign bus.an_4 = r_an[4];
  assign bus.an_5 = r_an[5];
  assign bus.an_6 = r_an[6];
  assign bus.an_7 = r_an[7];

endmodule

`default_nettype wire

// File: tb/tb_dsd_lab5.sv
// ============================================================================
//  Module      : tb_dsd_lab5
//  Description : Self-checking bench for dsd_lab5. Expected outputs come from
//                a letter-list model of the lit segments per hex digit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsd_lab5;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  dsd_lab5_if bus ();

  dsd_lab5 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs, packed {a,b,c,d,e,f,g} and {an_7..an_0}
  logic [6:0] obs_seg;
  logic [7:0] obs_an;
  assign obs_seg = {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d,
                    bus.seg_e, bus.seg_f, bus.seg_g};
  assign obs_an  = {bus.an_7, bus.an_6, bus.an_5, bus.an_4,
                    bus.an_3, bus.an_2, bus.an_1, bus.an_0};

  // Lit segments for each hex value, straight from the glyph list
  string lit_tbl [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                          "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                          "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  logic [6:0] exp_seg;
  logic [7:0] exp_an;

  function automatic logic [6:0] model_seg(input logic [3:0] v, input logic rn);
    logic [6:0] r;
    string      s;
    int         idx;
    r = 7'h7F;
    if (rn) begin
      s = lit_tbl[v];
      for (int j = 0; j < s.len(); j++) begin
        idx = int'(s[j]) - 97;
        r[6 - idx] = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] model_an(input logic [2:0] sel, input logic rn);
    logic [7:0] r;
    r = 8'hFF;
    for (int k = 0; k < 8; k++)
      if (rn && int'(sel) == k) r[k] = 1'b0;
    return r;
  endfunction

  // Drive one input set before an edge, then settle just after the edge and
  // record what the display should now show
  task automatic cycle(input logic [3:0] av, input logic [2:0] bv, input logic rn);
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
    rst_n = rn;
    @(posedge clk);
    #1;
    exp_seg = model_seg(av, rn);
    exp_an  = model_an(bv, rn);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(4'h8, 3'd3, 1'b0);
      checks++;
      if (obs_seg !== 7'h7F || obs_an !== 8'hFF) begin
        failures++;
        $display("FAIL reset_hold seg=%b an=%b want seg=1111111 an=11111111", obs_seg, obs_an);
      end
    end
    cycle(4'h8, 3'd3, 1'b1);
    checks++;
    if (obs_seg !== 7'h00 || obs_an !== 8'b1111_0111) begin
      failures++;
      $display("FAIL reset_release seg=%b an=%b want seg=0000000 an=11110111", obs_seg, obs_an);
    end
  endtask

  task automatic test_diagonal();
    for (int i = 0; i < 8; i++) begin
      cycle(4'(i), 3'(i), 1'b1);
      checks++;
      if (obs_seg !== exp_seg || obs_an !== exp_an) begin
        failures++;
        $display("FAIL diagonal_%0d seg=%b an=%b want seg=%b an=%b", i, obs_seg, obs_an, exp_seg, exp_an);
      end
    end
  endtask

  task automatic test_hex_sweep();
    for (int i = 0; i < 16; i++) begin
      cycle(4'(i), 3'd5, 1'b1);
      checks++;
      if (obs_seg !== exp_seg || obs_an !== 8'b1101_1111) begin
        failures++;
        $display("FAIL hex_sweep_%0h seg=%b an=%b want seg=%b an=11011111", i, obs_seg, obs_an, exp_seg);
      end
    end
  endtask

  task automatic test_anode_walk();
    for (int i = 0; i < 8; i++) begin
      cycle(4'h2, 3'(i), 1'b1);
      checks++;
      if (obs_an !== exp_an || $countones(~obs_an) != 1 || obs_seg !== 7'b0010010) begin
        failures++;
        $display("FAIL anode_walk_%0d seg=%b an=%b want seg=0010010 an=%b", i, obs_seg, obs_an, exp_an);
      end
    end
  endtask

  task automatic test_mid_reset();
    cycle(4'h6, 3'd2, 1'b1);
    checks++;
    if (obs_seg !== exp_seg || obs_an !== exp_an) begin
      failures++;
      $display("FAIL mid_reset_run seg=%b an=%b want seg=%b an=%b", obs_seg, obs_an, exp_seg, exp_an);
    end
    cycle(4'h6, 3'd2, 1'b0);
    checks++;
    if (obs_seg !== 7'h7F || obs_an !== 8'hFF) begin
      failures++;
      $display("FAIL mid_reset_dark seg=%b an=%b want seg=1111111 an=11111111", obs_seg, obs_an);
    end
    cycle(4'h6, 3'd2, 1'b1);
    checks++;
    if (obs_seg !== 7'b0100000 || obs_an !== 8'b1111_1011) begin
      failures++;
      $display("FAIL mid_reset_resume seg=%b an=%b want seg=0100000 an=11111011", obs_seg, obs_an);
    end
  endtask

  task automatic test_latency();
    cycle(4'h9, 3'd4, 1'b1);
    // Change the value between edges: outputs must still show 9
    @(negedge clk);
    bus.a = 4'h0;
    #1;
    checks++;
    if (obs_seg !== model_seg(4'h9, 1'b1) || obs_an !== exp_an) begin
      failures++;
      $display("FAIL latency_hold seg=%b an=%b want seg=%b an=%b", obs_seg, obs_an, model_seg(4'h9, 1'b1), exp_an);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs_seg !== 7'b0000001 || bus.seg_g !== 1'b1 || bus.seg_e !== 1'b0) begin
      failures++;
      $display("FAIL latency_update seg=%b want seg=0000001", obs_seg);
    end
  endtask

  task automatic test_random();
    logic [3:0] av;
    logic [2:0] bv;
    logic       rn;
    for (int i = 0; i < 300; i++) begin
      av = 4'($urandom_range(15, 0));
      bv = 3'($urandom_range(7, 0));
      rn = ($urandom_range(15, 0) != 0);
      cycle(av, bv, rn);
      checks++;
      if (obs_seg !== exp_seg || obs_an !== exp_an) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%0d rst_n=%b seg=%b an=%b want seg=%b an=%b",
                 i, av, bv, rn, obs_seg, obs_an, exp_seg, exp_an);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.a    = 4'h0;
    bus.b    = 3'd0;
    exp_seg  = 7'h7F;
    exp_an   = 8'hFF;
    test_reset();
    test_diagonal();
    test_hex_sweep();
    test_anode_walk();
    test_mid_reset();
    test_latency();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
